// File: rtl/prf_free_list.sv
// rtl/prf_free_list.sv - multi-lane circular free list of physical register indices with speculative/committed heads
// Optional feature macro: FREE_LIST_CHECK_EN (in_list tracker plus sticky err_double_free output).
module prf_free_list #(
  parameter int PRF_DEPTH   = 64,
  parameter int ARF_DEPTH   = 32,
  parameter int ALLOC_WIDTH = 1,
  parameter int FREE_WIDTH  = 1,
  localparam int PRF_IDX    = $clog2(PRF_DEPTH),
  localparam int FL_DEPTH   = PRF_DEPTH - ARF_DEPTH,
  localparam int PTR_W      = $clog2(FL_DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [ALLOC_WIDTH-1:0]                alloc_req,
  output logic                                  alloc_ready,
  output logic [ALLOC_WIDTH-1:0][PRF_IDX-1:0]   alloc_phy,
  input  logic [FREE_WIDTH-1:0]                 commit_valid,
  input  logic [FREE_WIDTH-1:0][PRF_IDX-1:0]    commit_old_phy,
  input  logic                                  flush,
  output logic [PTR_W-1:0]                      free_count
`ifdef FREE_LIST_CHECK_EN
  ,
  output logic                                  err_double_free
`endif
);

  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] FL_DEPTH_P = PTR_W'(FL_DEPTH);

  logic [PRF_IDX-1:0] entries [FL_DEPTH];
  logic [PTR_W-1:0] head_spec, head_cmt, tail;
  logic [PTR_W-1:0] head_spec_nxt, head_cmt_nxt, tail_nxt;
  logic [PTR_W-1:0] n_req, n_alloc, n_free;
  logic             alloc_fire;
  logic [FREE_WIDTH-1:0][IDX_W-1:0] wr_slot;

  // Advance a wrap-bit pointer by n, wrapping the index at FL_DEPTH and toggling the wrap bit.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [PTR_W-1:0] n);
    logic [PTR_W-1:0] s;
    logic             w;
    s = {1'b0, p[IDX_W-1:0]} + n;
    w = p[PTR_W-1];
    if (s >= FL_DEPTH_P) begin
      s = s - FL_DEPTH_P;
      w = ~w;
    end
    return {w, s[IDX_W-1:0]};
  endfunction

  // Occupancy between two pointers: a - b, where a is at or ahead of b.
  function automatic logic [PTR_W-1:0] ptr_diff(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
    logic [PTR_W-1:0] ai, bi;
    ai = {1'b0, a[IDX_W-1:0]};
    bi = {1'b0, b[IDX_W-1:0]};
    if (a[PTR_W-1] == b[PTR_W-1]) return ai - bi;
    return ai + FL_DEPTH_P - bi;
  endfunction

  assign alloc_ready = (free_count >= PTR_W'(ALLOC_WIDTH));

  // Compact requesting lanes onto consecutive entries starting at head_spec; zero-latency read.
  always_comb begin
    logic [PTR_W-1:0] cnt, p;
    cnt = '0;
    p   = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      p = ptr_add(head_spec, cnt);
      alloc_phy[i] = entries[p[IDX_W-1:0]];
      if (alloc_req[i]) cnt = cnt + PTR_W'(1);
    end
    n_req = cnt;
  end

  // Compact valid commit lanes onto consecutive slots starting at tail.
  always_comb begin
    logic [PTR_W-1:0] cnt, p;
    cnt = '0;
    p   = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      p = ptr_add(tail, cnt);
      wr_slot[i] = p[IDX_W-1:0];
      if (commit_valid[i]) cnt = cnt + PTR_W'(1);
    end
    n_free = cnt;
  end

  assign alloc_fire    = alloc_ready && (|alloc_req) && !flush;
  assign n_alloc       = alloc_fire ? n_req : '0;
  assign head_cmt_nxt  = ptr_add(head_cmt, n_free);
  assign tail_nxt      = ptr_add(tail, n_free);
  // A flush rewinds the speculative head to the committed head, including this cycle's commits.
  assign head_spec_nxt = flush ? head_cmt_nxt : ptr_add(head_spec, n_alloc);

  // Pointer, count and storage state; storage holds the non-architectural registers after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_spec  <= '0;
      head_cmt   <= '0;
      tail       <= {1'b1, {IDX_W{1'b0}}};
      free_count <= FL_DEPTH_P;
      for (int k = 0; k < FL_DEPTH; k++) begin
        entries[k] <= PRF_IDX'(ARF_DEPTH + k);
      end
    end else begin
      head_spec  <= head_spec_nxt;
      head_cmt   <= head_cmt_nxt;
      tail       <= tail_nxt;
      free_count <= ptr_diff(tail_nxt, head_spec_nxt);
      for (int i = 0; i < FREE_WIDTH; i++) begin
        if (commit_valid[i]) entries[wr_slot[i]] <= commit_old_phy[i];
      end
    end
  end

  // Simulation checks: commits may never outrun speculative allocations or overfill the list.
  always @(posedge clk) begin
    if (!rst) begin
      assert (n_free <= ptr_diff(head_spec, head_cmt))
        else $error("prf_free_list: head_cmt would pass head_spec");
      assert ((32'(ptr_diff(tail, head_spec)) + 32'(n_free)) <= 32'(FL_DEPTH))
        else $error("prf_free_list: free overflow, tail would pass head");
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic [PRF_DEPTH-1:0] in_list, in_list_base, in_list_nxt, rebuilt;
  logic                 flush_d, dbl_hit;

  // Membership rebuilt from the current free span [head_spec, tail) for use just after a flush.
  always_comb begin
    logic [PTR_W-1:0] span, off, hs;
    rebuilt = '0;
    span    = ptr_diff(tail, head_spec);
    hs      = {1'b0, head_spec[IDX_W-1:0]};
    off     = '0;
    for (int j = 0; j < FL_DEPTH; j++) begin
      if (PTR_W'(j) >= hs) off = PTR_W'(j) - hs;
      else                 off = PTR_W'(j) + FL_DEPTH_P - hs;
      if (off < span) rebuilt[entries[j]] = 1'b1;
    end
  end

  // Apply this cycle's allocations and frees, flagging frees of indices already in the list.
  always_comb begin
    in_list_base = flush_d ? rebuilt : in_list;
    in_list_nxt  = in_list_base;
    dbl_hit      = 1'b0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      if (alloc_fire && alloc_req[i]) in_list_nxt[alloc_phy[i]] = 1'b0;
    end
    for (int i = 0; i < FREE_WIDTH; i++) begin
      if (commit_valid[i]) begin
        if (in_list_base[commit_old_phy[i]]) dbl_hit = 1'b1;
        in_list_nxt[commit_old_phy[i]] = 1'b1;
      end
    end
  end

  // Membership register and sticky double-free flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PRF_DEPTH; k++) begin
        in_list[k] <= (k >= ARF_DEPTH);
      end
      flush_d         <= 1'b0;
      err_double_free <= 1'b0;
    end else begin
      in_list <= in_list_nxt;
      flush_d <= flush;
      if (dbl_hit) err_double_free <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// tb/tb_prf_free_list.sv - directed bench for prf_free_list (1-lane and 2-lane allocation instances)
module tb_prf_free_list;

  localparam int PRF_IDX = 6;
  localparam int PTR_W   = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [0:0]              alloc_req;
  logic                    alloc_ready;
  logic [0:0][PRF_IDX-1:0] alloc_phy;
  logic [0:0]              commit_valid;
  logic [0:0][PRF_IDX-1:0] commit_old_phy;
  logic [PTR_W-1:0]        free_count;
  logic [1:0]              alloc_req2;
  logic                    alloc_ready2;
  logic [1:0][PRF_IDX-1:0] alloc_phy2;
  logic [PTR_W-1:0]        free_count2;
`ifdef FREE_LIST_CHECK_EN
  logic                    err;
  logic                    err2;
`endif

  int vectors = 0;
  int miscompares = 0;

  prf_free_list u_dut (
    .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_ready(alloc_ready),
    .alloc_phy(alloc_phy), .commit_valid(commit_valid), .commit_old_phy(commit_old_phy),
    .flush(flush), .free_count(free_count)
`ifdef FREE_LIST_CHECK_EN
    , .err_double_free(err)
`endif
  );

  prf_free_list #(.ALLOC_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .alloc_req(alloc_req2), .alloc_ready(alloc_ready2),
    .alloc_phy(alloc_phy2), .commit_valid(1'b0), .commit_old_phy(6'd0),
    .flush(flush), .free_count(free_count2)
`ifdef FREE_LIST_CHECK_EN
    , .err_double_free(err2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_req = '0; commit_valid = '0; commit_old_phy = '0; alloc_req2 = '0;
    step();
    rst = 1'b0;
    #1;
    check("reset_free_count", 32'(free_count), 32'd32);
    check("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    check("reset_alloc_phy", 32'(alloc_phy[0]), 32'd32);
`ifdef FREE_LIST_CHECK_EN
    check("reset_err", 32'(err), 32'd0);
`endif

    // Two-lane instance: only lane 1 requests, then both lanes.
    alloc_req2 = 2'b10;
    #1;
    check("w2_lane1_first", 32'(alloc_phy2[1]), 32'd32);
    step();
    alloc_req2 = 2'b11;
    #1;
    check("w2_free_count_1", 32'(free_count2), 32'd31);
    check("w2_lane0", 32'(alloc_phy2[0]), 32'd33);
    check("w2_lane1", 32'(alloc_phy2[1]), 32'd34);
    step();
    alloc_req2 = 2'b00;
    #1;
    check("w2_free_count_3", 32'(free_count2), 32'd29);

    // Drain the whole list one entry per cycle.
    for (int k = 0; k < 32; k++) begin
      alloc_req = 1'b1;
      #1;
      check("drain_alloc_phy", 32'(alloc_phy[0]), 32'(32 + k));
      step();
    end
    #1;
    check("empty_alloc_ready", 32'(alloc_ready), 32'd0);
    check("empty_free_count", 32'(free_count), 32'd0);

    // Free into an empty list: no same-cycle bypass.
    commit_valid = 1'b1; commit_old_phy = 6'd5;
    #1;
    check("free_same_cycle_ready", 32'(alloc_ready), 32'd0);
    step();
    commit_valid = 1'b0;
    #1;
    check("free_next_ready", 32'(alloc_ready), 32'd1);
    check("free_next_phy", 32'(alloc_phy[0]), 32'd5);
    check("free_next_count", 32'(free_count), 32'd1);
    step();
    alloc_req = 1'b0;
    #1;
    check("realloc_count", 32'(free_count), 32'd0);

    // Mid-operation reset discards everything.
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rereset_count", 32'(free_count), 32'd32);
    check("rereset_phy", 32'(alloc_phy[0]), 32'd32);

    // Allocate 10, commit 3, then flush with one same-cycle commit.
    alloc_req = 1'b1;
    for (int k = 0; k < 10; k++) step();
    alloc_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      commit_valid = 1'b1; commit_old_phy = 6'(7 + k);
      step();
    end
    commit_valid = 1'b0;
    #1;
    check("pre_flush_count", 32'(free_count), 32'd25);
    flush = 1'b1; commit_valid = 1'b1; commit_old_phy = 6'd10; alloc_req = 1'b1;
    step();
    flush = 1'b0; commit_valid = 1'b0;
    #1;
    check("flush_count", 32'(free_count), 32'd32);
    check("flush_phy", 32'(alloc_phy[0]), 32'd36);
    step();
    alloc_req = 1'b0;
    #1;
    check("post_flush_count", 32'(free_count), 32'd31);
    check("post_flush_phy", 32'(alloc_phy[0]), 32'd37);

    // Alternating alloc/free across the wrap point.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ((k % 2) == 0) begin
        alloc_req = 1'b1; commit_valid = 1'b0;
        #1;
        check("wrap_alloc_phy", 32'(alloc_phy[0]), 32'(32 + ((k / 2) % 32)));
        check("wrap_count_before_alloc", 32'(free_count), 32'd32);
      end else begin
        alloc_req = 1'b0; commit_valid = 1'b1; commit_old_phy = 6'(32 + ((k / 2) % 32));
        #1;
        check("wrap_count_before_free", 32'(free_count), 32'd31);
      end
      step();
    end
    alloc_req = 1'b0; commit_valid = 1'b0;
    #1;
    check("wrap_final_count", 32'(free_count), 32'd32);

`ifdef FREE_LIST_CHECK_EN
    check("no_false_double_free", 32'(err), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    alloc_req = 1'b1;
    step();
    alloc_req = 1'b0; commit_valid = 1'b1; commit_old_phy = 6'd40;
    step();
    commit_valid = 1'b0;
    #1;
    check("double_free_set", 32'(err), 32'd1);
    step();
    step();
    check("double_free_sticky", 32'(err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("double_free_cleared", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
